// File: rtl/conv_pkg.sv
// Shared widths, types and small helpers for the window address generator.
package conv_pkg;

    localparam int ADDR_W   = 4;
    localparam int FSIZE_W  = 4;
    localparam int STRIDE_W = 3;
    localparam int NUM_FILT = 4;
    localparam int FADDR_W  = 6;

    localparam int ROW_LEN  = 1 << ADDR_W;
    localparam int FIDX_W   = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
    // Window-end sums are formed two bits wider than the row address so they never wrap.
    localparam int SUM_W    = ADDR_W + 2;

    typedef logic [ADDR_W-1:0]   if_addr_t;
    typedef logic [FADDR_W-1:0]  filt_addr_t;
    typedef logic [FSIZE_W-1:0]  fsize_t;
    typedef logic [STRIDE_W-1:0] stride_t;
    typedef logic [FIDX_W-1:0]   filt_idx_t;
    typedef logic [SUM_W-1:0]    sum_t;

    // A zero filter size is meaningless; treat it as a single-element window.
    function automatic fsize_t nz_fsize(input fsize_t v);
        return (v == '0) ? fsize_t'(1) : v;
    endfunction

    // A zero stride would never advance; treat it as a stride of one.
    function automatic stride_t nz_stride(input stride_t v);
        return (v == '0) ? stride_t'(1) : v;
    endfunction

    // True when a window of this size cannot fit even at the start of the row.
    function automatic logic too_wide(input fsize_t f);
        return sum_t'(f) > sum_t'(ROW_LEN);
    endfunction

endpackage

// File: rtl/window_addr_gen_if.sv
// Command / status bundle between window_addr_gen and main_controller.
interface window_addr_gen_if;
    import conv_pkg::*;

    logic       ld_stride;
    logic       ld_filterSize;
    stride_t    stride_in;
    fsize_t     fsize_in;
    logic       put_data;
    logic       next_filter;
    logic       next_row;

    if_addr_t   if_raddr;
    filt_addr_t filt_raddr;
    logic       co_filter;
    logic       end_of_row;
    logic       end_of_filter;
    logic       row_done;

    // Controller side: issues commands, observes addresses and flags.
    modport master (
        output ld_stride, ld_filterSize, stride_in, fsize_in,
               put_data, next_filter, next_row,
        input  if_raddr, filt_raddr, co_filter, end_of_row, end_of_filter, row_done
    );

    // Generator side.
    modport slave (
        input  ld_stride, ld_filterSize, stride_in, fsize_in,
               put_data, next_filter, next_row,
        output if_raddr, filt_raddr, co_filter, end_of_row, end_of_filter, row_done
    );

endinterface

// File: rtl/window_counter.sv
// Element index k within the current window and the window base address.
// Advances on step; wraps k and moves the base by stride at the last element.
module window_counter
    import conv_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     clr,
    input  logic     step,
    input  fsize_t   fsize,
    input  stride_t  stride,
    output if_addr_t win_base,
    output fsize_t   k,
    output logic     win_done
);

    logic last;

    assign last     = (k == fsize - fsize_t'(1));
    assign win_done = step & last;

    // Restart on clr; otherwise step through elements, then slide the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            win_base <= '0;
        end else if (clr) begin
            k        <= '0;
            win_base <= '0;
        end else if (step) begin
            if (last) begin
                k        <= '0;
                win_base <= win_base + if_addr_t'(stride);
            end else begin
                k        <= k + fsize_t'(1);
            end
        end
    end

endmodule

// File: rtl/window_addr_gen.sv
// Sliding-window address generator for one IFMap row across all resident filters.
// Holds stride/size configuration, filter index, end-of-row status and the command priority
// (load > next_row > next_filter > put_data).
module window_addr_gen
    import conv_pkg::*;
(
    input logic               clk,
    input logic               rst,
    window_addr_gen_if.slave  bus
);

    stride_t   stride_r;
    fsize_t    fsize_r;
    filt_idx_t filt_idx;
    logic      eor_r;
    logic      eor_nxt;
    logic      row_done_r;

    logic      cmd_ld;
    logic      cmd_row;
    logic      cmd_filt;
    logic      cmd_clr;
    logic      step;

    if_addr_t  win_base;
    fsize_t    k;
    logic      win_done;

    fsize_t    fsize_nxt;
    sum_t      next_end;

    // Priority decode: a higher command masks everything below it.
    assign cmd_ld   = bus.ld_stride | bus.ld_filterSize;
    assign cmd_row  = ~cmd_ld & bus.next_row;
    assign cmd_filt = ~cmd_ld & ~bus.next_row & bus.next_filter;
    assign cmd_clr  = cmd_ld | bus.next_row | bus.next_filter;
    assign step     = ~cmd_clr & bus.put_data & ~eor_r;

    // Size that will be in force after this cycle, used for the post-load row check.
    assign fsize_nxt = bus.ld_filterSize ? nz_fsize(bus.fsize_in) : fsize_r;

    // End of the window following the one just completed, in the wide sum domain.
    assign next_end = sum_t'(win_base) + sum_t'(stride_r) + sum_t'(fsize_r);

    window_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cmd_clr),
        .step     (step),
        .fsize    (fsize_r),
        .stride   (stride_r),
        .win_base (win_base),
        .k        (k),
        .win_done (win_done)
    );

    // Configuration registers; zero loads are promoted to one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_r <= stride_t'(1);
            fsize_r  <= fsize_t'(1);
        end else begin
            if (bus.ld_stride)     stride_r <= nz_stride(bus.stride_in);
            if (bus.ld_filterSize) fsize_r  <= nz_fsize(bus.fsize_in);
        end
    end

    // Filter index: cleared by load/next_row, advanced with wrap by next_filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_idx <= '0;
        end else if (cmd_ld || cmd_row) begin
            filt_idx <= '0;
        end else if (cmd_filt) begin
            if (filt_idx == filt_idx_t'(NUM_FILT - 1)) filt_idx <= '0;
            else                                       filt_idx <= filt_idx + filt_idx_t'(1);
        end
    end

    // Next end-of-row value: re-evaluated on restart, or looked ahead on window completion.
    always_comb begin
        eor_nxt = eor_r;
        if (cmd_ld)                        eor_nxt = too_wide(fsize_nxt);
        else if (cmd_row || cmd_filt)      eor_nxt = too_wide(fsize_r);
        else if (win_done)                 eor_nxt = next_end > sum_t'(ROW_LEN);
    end

    // End-of-row flag and the one-cycle row-done acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eor_r      <= 1'b0;
            row_done_r <= 1'b0;
        end else begin
            eor_r      <= eor_nxt;
            row_done_r <= cmd_row;
        end
    end

    assign bus.if_raddr      = win_base + if_addr_t'(k);
    assign bus.filt_raddr    = filt_addr_t'(filt_idx) * filt_addr_t'(fsize_r) + filt_addr_t'(k);
    assign bus.co_filter     = win_done;
    assign bus.end_of_row    = eor_r;
    assign bus.end_of_filter = (filt_idx == filt_idx_t'(NUM_FILT - 1));
    assign bus.row_done      = row_done_r;

endmodule

// File: tb/tb_window_addr_gen.sv
// Directed and randomized checks of window_addr_gen against a count-based reference model:
// the model tracks only how many put_data steps were accepted since the last restart and
// derives window number, element, base and end-of-row from that count.
module tb_window_addr_gen;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    window_addr_gen_if bus();

    window_addr_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int co_cnt = 0;

    // Reference state
    int   m_stride, m_fsize, m_n, m_filt;
    logic m_rd;

    function automatic int m_k();    return m_n % m_fsize;              endfunction
    function automatic int m_base(); return (m_n / m_fsize) * m_stride; endfunction
    function automatic logic m_eor(); return (m_base() + m_fsize) > ROW_LEN; endfunction

    task automatic model_reset();
        m_stride = 1; m_fsize = 1; m_n = 0; m_filt = 0; m_rd = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_state();
        chk("if_raddr",      32'(bus.if_raddr),      32'((m_base() + m_k()) % ROW_LEN));
        chk("filt_raddr",    32'(bus.filt_raddr),    32'(m_filt * m_fsize + m_k()));
        chk("end_of_row",    32'(bus.end_of_row),    32'(m_eor()));
        chk("end_of_filter", 32'(bus.end_of_filter), 32'(m_filt == NUM_FILT - 1));
        chk("row_done",      32'(bus.row_done),      32'(m_rd));
    endtask

    task automatic idle_inputs();
        bus.ld_stride = 1'b0; bus.ld_filterSize = 1'b0;
        bus.stride_in = '0;   bus.fsize_in = '0;
        bus.put_data = 1'b0;  bus.next_filter = 1'b0; bus.next_row = 1'b0;
    endtask

    // One clock of stimulus: combinational co_filter is checked before the edge,
    // registered state after it.
    task automatic step(input bit lds, input bit ldf, input int s, input int f,
                        input bit put, input bit nf, input bit nr);
        logic exp_co;
        @(negedge clk);
        bus.ld_stride = lds; bus.ld_filterSize = ldf;
        bus.stride_in = stride_t'(s); bus.fsize_in = fsize_t'(f);
        bus.put_data = put; bus.next_filter = nf; bus.next_row = nr;
        #1;
        exp_co = put && !lds && !ldf && !nf && !nr && !m_eor() && (m_k() == m_fsize - 1);
        chk("co_filter", 32'(bus.co_filter), 32'(exp_co));
        if (bus.co_filter === 1'b1) co_cnt++;
        @(posedge clk);
        m_rd = 1'b0;
        if (lds || ldf) begin
            if (lds) m_stride = (s == 0) ? 1 : s;
            if (ldf) m_fsize  = (f == 0) ? 1 : f;
            m_n = 0; m_filt = 0;
        end else if (nr) begin
            m_n = 0; m_filt = 0; m_rd = 1'b1;
        end else if (nf) begin
            m_n = 0; m_filt = (m_filt + 1) % NUM_FILT;
        end else if (put && !m_eor()) begin
            m_n++;
        end
        #1;
        check_state();
    endtask

    task automatic put(); step(0, 0, 0, 0, 1, 0, 0); endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b1;
        #1;
        check_state();
        chk("reset_co", 32'(bus.co_filter), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // 1: fsize=3, stride=2 across a 16-entry row
        step(1, 1, 2, 3, 0, 0, 0);
        co_cnt = 0;
        repeat (20) put();
        chk("t1_eor_before_last", 32'(bus.end_of_row), 32'(0));
        put();
        chk("t1_co_count", 32'(co_cnt), 32'(7));
        chk("t1_eor", 32'(bus.end_of_row), 32'(1));

        // 2: puts after end_of_row are ignored
        co_cnt = 0;
        repeat (5) put();
        chk("t2_co_count", 32'(co_cnt), 32'(0));
        chk("t2_if_frozen", 32'(bus.if_raddr), 32'(14));

        // 3: walk filters
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("t3_filt_raddr", 32'(bus.filt_raddr), 32'(6));
        chk("t3_if_raddr", 32'(bus.if_raddr), 32'(0));
        chk("t3_eor", 32'(bus.end_of_row), 32'(0));
        step(0, 0, 0, 0, 0, 1, 0);
        chk("t3_eof", 32'(bus.end_of_filter), 32'(1));

        // 4: next_row wins over next_filter
        step(0, 0, 0, 0, 0, 1, 1);
        chk("t4_row_done", 32'(bus.row_done), 32'(1));
        chk("t4_eof", 32'(bus.end_of_filter), 32'(0));
        idle_inputs();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t4_row_done_pulse", 32'(bus.row_done), 32'(0));

        // 5: zero size becomes one; widest filter fits only once
        step(0, 1, 0, 0, 0, 0, 0);
        co_cnt = 0;
        repeat (4) put();
        chk("t5_co_every_put", 32'(co_cnt), 32'(4));
        step(1, 1, 4, 15, 0, 0, 0);
        co_cnt = 0;
        repeat (14) put();
        chk("t5_eor_before", 32'(bus.end_of_row), 32'(0));
        put();
        chk("t5_eor", 32'(bus.end_of_row), 32'(1));
        chk("t5_co_count", 32'(co_cnt), 32'(1));

        // 6: asynchronous reset mid-window (win_base=6, k=2)
        step(1, 1, 2, 3, 0, 0, 0);
        repeat (11) put();
        chk("t6_pre_if", 32'(bus.if_raddr), 32'(8));
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_state();
        @(negedge clk);
        rst = 1'b0;
        co_cnt = 0;
        repeat (3) put();
        chk("t6_unit_cfg_co", 32'(co_cnt), 32'(3));
        chk("t6_unit_cfg_if", 32'(bus.if_raddr), 32'(3));

        // Randomized traffic
        repeat (600) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3)
                step(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            else if (r < 5)
                step(1'b1, 1'b0, int'($urandom_range(0, 7)), 0, 1'b1, 1'b0, 1'b0);
            else if (r < 8)
                step(1'b0, 1'b0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            else if (r < 14)
                step(1'b0, 1'b0, 0, 0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            else if (r < 85)
                put();
            else
                step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
